// File: rtl/s_axi_read_regbank_pkg.sv
// Sequencer register-map package: address field layout, field offsets for both
// banks, AXI response codes and the read responder state type.
package s_axi_read_regbank_pkg;

    localparam int unsigned FIELD_LSB      = 2;
    localparam int unsigned FIELD_WIDTH    = 3;
    localparam int unsigned SLOT_LSB       = 5;
    localparam int unsigned BANK_SEL_BIT   = 12;
    localparam int unsigned ADDR_UPPER_LSB = 13;

    localparam logic [FIELD_WIDTH-1:0] B0_CONTROL  = 3'd0;
    localparam logic [FIELD_WIDTH-1:0] B0_STATUS   = 3'd1;
    localparam logic [FIELD_WIDTH-1:0] B0_CNT      = 3'd2;

    localparam logic [FIELD_WIDTH-1:0] B1_SRC_ADDR = 3'd0;
    localparam logic [FIELD_WIDTH-1:0] B1_SRC_SIZE = 3'd1;
    localparam logic [FIELD_WIDTH-1:0] B1_DST_ADDR = 3'd2;
    localparam logic [FIELD_WIDTH-1:0] B1_DST_SIZE = 3'd3;
    localparam logic [FIELD_WIDTH-1:0] B1_STATUS   = 3'd4;
    localparam logic [FIELD_WIDTH-1:0] B1_PROFILE  = 3'd5;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;
    localparam logic [1:0] RESP_DECERR = 2'b11;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_DECODE = 2'd1,
        ST_RESP   = 2'd2
    } rd_state_t;

endpackage

// File: rtl/s_axi_read_regmux.sv
// Combinational decode of a latched read address into zero-extended field data
// and an AXI response code.
module s_axi_read_regmux
    import s_axi_read_regbank_pkg::*;
#(
    parameter int GLOB_ADDR_WIDTH      = 32,
    parameter int GLOB_DATA_WIDTH      = 32,
    parameter int BANK1_SRC_ADDR_WIDTH = 32,
    parameter int BANK1_SRC_SIZE_WIDTH = 26,
    parameter int BANK1_DST_ADDR_WIDTH = 32,
    parameter int BANK1_DST_SIZE_WIDTH = 26,
    parameter int BANK1_STATUS_WIDTH   = 2,
    parameter int BANK1_PROFILE_WIDTH  = 32,
    parameter int BANK0_CONTROL_WIDTH  = 4,
    parameter int BANK0_STATUS_WIDTH   = 4,
    parameter int BANK0_CNT_WIDTH      = 2
) (
    input  logic [GLOB_ADDR_WIDTH-1:0]      i_addr,
    input  logic [BANK0_CONTROL_WIDTH-1:0]  i_bank0_control,
    input  logic [BANK0_STATUS_WIDTH-1:0]   i_bank0_status,
    input  logic [BANK0_CNT_WIDTH-1:0]      i_bank0_cnt,
    input  logic [BANK1_SRC_ADDR_WIDTH-1:0] i_bank1_src_addr,
    input  logic [BANK1_SRC_SIZE_WIDTH-1:0] i_bank1_src_size,
    input  logic [BANK1_DST_ADDR_WIDTH-1:0] i_bank1_dst_addr,
    input  logic [BANK1_DST_SIZE_WIDTH-1:0] i_bank1_dst_size,
    input  logic [BANK1_STATUS_WIDTH-1:0]   i_bank1_status,
    input  logic [BANK1_PROFILE_WIDTH-1:0]  i_bank1_profile,
    output logic [GLOB_DATA_WIDTH-1:0]      o_data,
    output logic [1:0]                      o_resp
);

    logic [FIELD_WIDTH-1:0] w_field;
    logic                   w_upper_hit;
    logic                   w_unused;

    assign w_field     = i_addr[FIELD_LSB +: FIELD_WIDTH];
    assign w_upper_hit = (i_addr >> ADDR_UPPER_LSB) != '0;
    // Low byte-lane bits and slot/alias bits play no part in the data select.
    assign w_unused    = ^{i_addr[BANK_SEL_BIT-1:FIELD_LSB+FIELD_WIDTH], i_addr[FIELD_LSB-1:0]};

    always_comb begin
        // NOTE: defaults first so every path assigns both outputs and no latch is inferred.
        o_data = '0;
        o_resp = RESP_OKAY;
        if (w_upper_hit) begin
            o_resp = RESP_DECERR;
        end else if (!i_addr[BANK_SEL_BIT]) begin
            case (w_field)
                B0_CONTROL: o_data = GLOB_DATA_WIDTH'(i_bank0_control);
                B0_STATUS:  o_data = GLOB_DATA_WIDTH'(i_bank0_status);
                B0_CNT:     o_data = GLOB_DATA_WIDTH'(i_bank0_cnt);
                default:    o_resp = RESP_SLVERR;
            endcase
        end else begin
            case (w_field)
                B1_SRC_ADDR: o_data = GLOB_DATA_WIDTH'(i_bank1_src_addr);
                B1_SRC_SIZE: o_data = GLOB_DATA_WIDTH'(i_bank1_src_size);
                B1_DST_ADDR: o_data = GLOB_DATA_WIDTH'(i_bank1_dst_addr);
                B1_DST_SIZE: o_data = GLOB_DATA_WIDTH'(i_bank1_dst_size);
                B1_STATUS:   o_data = GLOB_DATA_WIDTH'(i_bank1_status);
                B1_PROFILE:  o_data = GLOB_DATA_WIDTH'(i_bank1_profile);
                default:     o_resp = RESP_SLVERR;
            endcase
        end
    end

endmodule

// File: rtl/s_axi_read_regbank.sv
// AXI4-Lite read responder for the sequencer register banks: one outstanding
// read, AR latched in IDLE, field selected in DECODE, response held in RESP.
module s_axi_read_regbank
    import s_axi_read_regbank_pkg::*;
#(
    parameter int GLOB_ADDR_WIDTH      = 32,
    parameter int GLOB_DATA_WIDTH      = 32,
    parameter int BANK1_INDEX_WIDTH    = 2,
    parameter int BANK1_SRC_ADDR_WIDTH = 32,
    parameter int BANK1_SRC_SIZE_WIDTH = 26,
    parameter int BANK1_DST_ADDR_WIDTH = 32,
    parameter int BANK1_DST_SIZE_WIDTH = 26,
    parameter int BANK1_STATUS_WIDTH   = 2,
    parameter int BANK1_PROFILE_WIDTH  = 32,
    parameter int BANK0_CONTROL_WIDTH  = 4,
    parameter int BANK0_STATUS_WIDTH   = 4,
    parameter int BANK0_CNT_WIDTH      = BANK1_INDEX_WIDTH
) (
    input  logic                            clk,
    input  logic                            reset,
    input  logic [GLOB_ADDR_WIDTH-1:0]      S_AXI_ARADDR,
    input  logic                            S_AXI_ARVALID,
    output logic                            S_AXI_ARREADY,
    output logic [GLOB_DATA_WIDTH-1:0]      S_AXI_RDATA,
    output logic [1:0]                      S_AXI_RRESP,
    output logic                            S_AXI_RVALID,
    input  logic                            S_AXI_RREADY,
    input  logic [BANK0_CONTROL_WIDTH-1:0]  bank0_control,
    input  logic [BANK0_STATUS_WIDTH-1:0]   bank0_status,
    input  logic [BANK0_CNT_WIDTH-1:0]      bank0_cnt,
    output logic [BANK1_INDEX_WIDTH-1:0]    bank1_rd_idx,
    input  logic [BANK1_SRC_ADDR_WIDTH-1:0] bank1_src_addr,
    input  logic [BANK1_SRC_SIZE_WIDTH-1:0] bank1_src_size,
    input  logic [BANK1_DST_ADDR_WIDTH-1:0] bank1_dst_addr,
    input  logic [BANK1_DST_SIZE_WIDTH-1:0] bank1_dst_size,
    input  logic [BANK1_STATUS_WIDTH-1:0]   bank1_status,
    input  logic [BANK1_PROFILE_WIDTH-1:0]  bank1_profile,
    output logic                            rd_done
);

    rd_state_t                  r_state;
    logic [GLOB_ADDR_WIDTH-1:0] r_addr;
    logic                       r_arready;
    logic                       r_rvalid;
    logic [GLOB_DATA_WIDTH-1:0] r_rdata;
    logic [1:0]                 r_rresp;
    logic                       r_rd_done;
    logic [GLOB_DATA_WIDTH-1:0] w_data;
    logic [1:0]                 w_resp;

    // The slot select only moves on an AR handshake, so it holds between reads.
    assign bank1_rd_idx = r_addr[SLOT_LSB +: BANK1_INDEX_WIDTH];

    s_axi_read_regmux #(
        .GLOB_ADDR_WIDTH      (GLOB_ADDR_WIDTH),
        .GLOB_DATA_WIDTH      (GLOB_DATA_WIDTH),
        .BANK1_SRC_ADDR_WIDTH (BANK1_SRC_ADDR_WIDTH),
        .BANK1_SRC_SIZE_WIDTH (BANK1_SRC_SIZE_WIDTH),
        .BANK1_DST_ADDR_WIDTH (BANK1_DST_ADDR_WIDTH),
        .BANK1_DST_SIZE_WIDTH (BANK1_DST_SIZE_WIDTH),
        .BANK1_STATUS_WIDTH   (BANK1_STATUS_WIDTH),
        .BANK1_PROFILE_WIDTH  (BANK1_PROFILE_WIDTH),
        .BANK0_CONTROL_WIDTH  (BANK0_CONTROL_WIDTH),
        .BANK0_STATUS_WIDTH   (BANK0_STATUS_WIDTH),
        .BANK0_CNT_WIDTH      (BANK0_CNT_WIDTH)
    ) u_regmux (
        .i_addr           (r_addr),
        .i_bank0_control  (bank0_control),
        .i_bank0_status   (bank0_status),
        .i_bank0_cnt      (bank0_cnt),
        .i_bank1_src_addr (bank1_src_addr),
        .i_bank1_src_size (bank1_src_size),
        .i_bank1_dst_addr (bank1_dst_addr),
        .i_bank1_dst_size (bank1_dst_size),
        .i_bank1_status   (bank1_status),
        .i_bank1_profile  (bank1_profile),
        .o_data           (w_data),
        .o_resp           (w_resp)
    );

    // NOTE: non-blocking assignments throughout so every register samples pre-edge values.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state   <= ST_IDLE;
            r_addr    <= '0;
            r_arready <= 1'b0;
            r_rvalid  <= 1'b0;
            r_rdata   <= '0;
            r_rresp   <= RESP_OKAY;
            r_rd_done <= 1'b0;
        end else begin
            r_rd_done <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    r_arready <= 1'b1;
                    if (S_AXI_ARVALID && r_arready) begin
                        r_addr    <= S_AXI_ARADDR;
                        r_arready <= 1'b0;
                        r_state   <= ST_DECODE;
                    end
                end
                ST_DECODE: begin
                    r_rdata  <= w_data;
                    r_rresp  <= w_resp;
                    r_rvalid <= 1'b1;
                    r_state  <= ST_RESP;
                end
                ST_RESP: begin
                    if (S_AXI_RREADY) begin
                        r_rvalid  <= 1'b0;
                        r_rd_done <= 1'b1;
                        r_arready <= 1'b1;
                        r_state   <= ST_IDLE;
                    end
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    assign S_AXI_ARREADY = r_arready;
    assign S_AXI_RVALID  = r_rvalid;
    assign S_AXI_RDATA   = r_rdata;
    assign S_AXI_RRESP   = r_rresp;
    assign rd_done       = r_rd_done;

endmodule

// File: tb/tb_s_axi_read_regbank.sv
// Randomized self-checking bench for s_axi_read_regbank against an
// address-arithmetic model of the register map.
module tb_s_axi_read_regbank;

    logic        clk = 1'b0;
    logic        reset;
    logic [31:0] araddr;
    logic        arvalid;
    logic        arready;
    logic [31:0] rdata;
    logic [1:0]  rresp;
    logic        rvalid;
    logic        rready;
    logic [3:0]  bank0_control;
    logic [3:0]  bank0_status;
    logic [1:0]  bank0_cnt;
    logic [1:0]  bank1_rd_idx;
    logic [31:0] bank1_src_addr;
    logic [25:0] bank1_src_size;
    logic [31:0] bank1_dst_addr;
    logic [25:0] bank1_dst_size;
    logic [1:0]  bank1_status;
    logic [31:0] bank1_profile;
    logic        rd_done;

    logic [31:0] m_src_addr [4];
    logic [25:0] m_src_size [4];
    logic [31:0] m_dst_addr [4];
    logic [25:0] m_dst_size [4];
    logic [1:0]  m_status   [4];
    logic [31:0] m_profile  [4];

    int n_checks = 0;
    int n_bad    = 0;

    assign bank1_src_addr = m_src_addr[bank1_rd_idx];
    assign bank1_src_size = m_src_size[bank1_rd_idx];
    assign bank1_dst_addr = m_dst_addr[bank1_rd_idx];
    assign bank1_dst_size = m_dst_size[bank1_rd_idx];
    assign bank1_status   = m_status[bank1_rd_idx];
    assign bank1_profile  = m_profile[bank1_rd_idx];

    always #5 clk = ~clk;

    s_axi_read_regbank dut (
        .clk            (clk),
        .reset          (reset),
        .S_AXI_ARADDR   (araddr),
        .S_AXI_ARVALID  (arvalid),
        .S_AXI_ARREADY  (arready),
        .S_AXI_RDATA    (rdata),
        .S_AXI_RRESP    (rresp),
        .S_AXI_RVALID   (rvalid),
        .S_AXI_RREADY   (rready),
        .bank0_control  (bank0_control),
        .bank0_status   (bank0_status),
        .bank0_cnt      (bank0_cnt),
        .bank1_rd_idx   (bank1_rd_idx),
        .bank1_src_addr (bank1_src_addr),
        .bank1_src_size (bank1_src_size),
        .bank1_dst_addr (bank1_dst_addr),
        .bank1_dst_size (bank1_dst_size),
        .bank1_status   (bank1_status),
        .bank1_profile  (bank1_profile),
        .rd_done        (rd_done)
    );

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h want %0h", tag, obs, exp);
        end
    endtask

    task automatic randomize_banks();
        bank0_control = 4'($urandom);
        bank0_status  = 4'($urandom);
        bank0_cnt     = 2'($urandom);
        for (int s = 0; s < 4; s++) begin
            m_src_addr[s] = $urandom;
            m_src_size[s] = 26'($urandom);
            m_dst_addr[s] = $urandom;
            m_dst_size[s] = 26'($urandom);
            m_status[s]   = 2'($urandom);
            m_profile[s]  = $urandom;
        end
    endtask

    // Register-map model written as plain address arithmetic.
    function automatic void model(input logic [31:0] a, output logic [31:0] d, output logic [1:0] r);
        int unsigned bank  = (a / 4096) % 2;
        int unsigned field = (a / 4) % 8;
        int unsigned slot  = (a / 32) % 4;
        d = 32'd0;
        r = 2'b00;
        if (a >= 32'd8192) begin
            r = 2'b11;
        end else if (bank == 0) begin
            if (field == 0)      d = {28'd0, bank0_control};
            else if (field == 1) d = {28'd0, bank0_status};
            else if (field == 2) d = {30'd0, bank0_cnt};
            else                 r = 2'b10;
        end else begin
            if (field == 0)      d = m_src_addr[slot];
            else if (field == 1) d = {6'd0, m_src_size[slot]};
            else if (field == 2) d = m_dst_addr[slot];
            else if (field == 3) d = {6'd0, m_dst_size[slot]};
            else if (field == 4) d = {30'd0, m_status[slot]};
            else if (field == 5) d = m_profile[slot];
            else                 r = 2'b10;
        end
    endfunction

    task automatic wait_arready(output bit ok);
        int budget = 0;
        while (!arready && budget < 10) begin
            @(negedge clk);
            budget++;
        end
        ok = arready;
        if (!ok) check("ar_timeout", 64'(arready), 64'd1);
    endtask

    task automatic do_read(input logic [31:0] a, input int hold);
        logic [31:0] ed;
        logic [1:0]  er;
        bit          ok;
        @(negedge clk);
        araddr  = a;
        arvalid = 1'b1;
        rready  = (hold == 0);
        wait_arready(ok);
        if (!ok) begin
            arvalid = 1'b0;
            return;
        end
        @(posedge clk);
        #1;
        arvalid = 1'b0;
        araddr  = $urandom;
        check("arready_decode", 64'(arready), 64'd0);
        check("rvalid_decode", 64'(rvalid), 64'd0);
        check("rd_idx_decode", 64'(bank1_rd_idx), 64'((a / 32) % 4));
        model(a, ed, er);
        @(posedge clk);
        #1;
        check("rvalid_rise", 64'(rvalid), 64'd1);
        check("rdata", 64'(rdata), 64'(ed));
        check("rresp", 64'(rresp), 64'(er));
        for (int i = 0; i < hold; i++) begin
            randomize_banks();
            arvalid = 1'($urandom);
            araddr  = $urandom;
            @(posedge clk);
            #1;
            check("rvalid_hold", 64'(rvalid), 64'd1);
            check("rdata_hold", 64'(rdata), 64'(ed));
            check("rresp_hold", 64'(rresp), 64'(er));
            check("arready_hold", 64'(arready), 64'd0);
            check("rd_done_hold", 64'(rd_done), 64'd0);
        end
        arvalid = 1'b0;
        rready  = 1'b1;
        @(posedge clk);
        #1;
        rready = 1'b0;
        check("rvalid_clear", 64'(rvalid), 64'd0);
        check("rd_done_pulse", 64'(rd_done), 64'd1);
        check("arready_back", 64'(arready), 64'd1);
        @(posedge clk);
        #1;
        check("rd_done_once", 64'(rd_done), 64'd0);
    endtask

    task automatic check_reset_values(input string tag);
        check({tag, "_arready"}, 64'(arready), 64'd0);
        check({tag, "_rvalid"}, 64'(rvalid), 64'd0);
        check({tag, "_rdata"}, 64'(rdata), 64'd0);
        check({tag, "_rresp"}, 64'(rresp), 64'd0);
        check({tag, "_rd_done"}, 64'(rd_done), 64'd0);
        check({tag, "_rd_idx"}, 64'(bank1_rd_idx), 64'd0);
    endtask

    // Starts a bank1 read, asserts reset after `extra` cycles past the AR handshake.
    task automatic reset_mid_read(input int extra, input string tag);
        bit ok;
        randomize_banks();
        @(negedge clk);
        araddr  = 32'h0000_1074;
        arvalid = 1'b1;
        rready  = 1'b0;
        wait_arready(ok);
        @(posedge clk);
        #1;
        arvalid = 1'b0;
        for (int i = 0; i < extra; i++) begin
            @(posedge clk);
            #1;
        end
        if (extra > 0) check({tag, "_pre_rvalid"}, 64'(rvalid), 64'd1);
        reset = 1'b0;
        #1;
        check_reset_values(tag);
        @(negedge clk);
        @(negedge clk);
        reset = 1'b1;
        rready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(posedge clk);
            #1;
            check({tag, "_no_resp"}, 64'(rvalid), 64'd0);
            check({tag, "_no_done"}, 64'(rd_done), 64'd0);
        end
        rready = 1'b0;
        do_read(32'h0000_0000, 1);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        reset   = 1'b0;
        araddr  = '0;
        arvalid = 1'b0;
        rready  = 1'b0;
        randomize_banks();
        repeat (3) @(posedge clk);
        #1;
        check_reset_values("reset");
        @(negedge clk);
        reset = 1'b1;
        #1;
        check("arready_release", 64'(arready), 64'd0);
        @(posedge clk);
        #1;
        check("arready_after_release", 64'(arready), 64'd1);

        bank0_status = 4'hA;
        do_read(32'h0000_0004, 1);
        m_profile[3] = 32'hDEAD_BEEF;
        do_read(32'h0000_1074, 0);
        m_src_size[3] = 26'h3FF_FFFF;
        do_read(32'h0000_1064, 0);
        do_read(32'h0000_000C, 1);
        do_read(32'h0000_1018, 1);
        do_read(32'h0001_0000, 1);
        do_read(32'h8000_1074, 0);
        do_read(32'h0000_1F94, 0);
        randomize_banks();
        do_read(32'h0000_1050, 5);

        for (int n = 0; n < 40; n++) begin
            logic [31:0] a;
            randomize_banks();
            a = {19'd0, 1'($urandom), 5'($urandom), 2'($urandom), 3'($urandom), 2'($urandom)};
            if ($urandom_range(0, 7) == 0) a = a | (32'd1 << $urandom_range(13, 31));
            do_read(a, $urandom_range(0, 3));
        end

        reset_mid_read(0, "rst_decode");
        reset_mid_read(1, "rst_resp");

        $display("test done: total=%0d bad=%0d", n_checks, n_bad);
        $finish;
    end

endmodule
